mmio_master: RTL and testbench
==============================

// Module: mmio_master
// PURPOSE
//  Memory-stage bus initiator for the memory-mapped I/O region (address bit MMIO_BIT = 1), which the block RAM ignores.
//  Sits beside RAM in the MEM stage. Consumes the same Signals bundle and turns loads and stores into valid/ready bus requests.
//  Stalls the pipeline until the peripheral responds, then emits lane-aligned, sign/zero-extended writeback data.
//  The MEM-stage mux selects o_signals from this block when the registered address has bit MMIO_BIT set.
// PARAMETERS
//  MMIO_BIT        24   address bit that selects the MMIO region
//  TIMEOUT_CYCLES  255  cycles from REQ entry before the transaction is aborted with a fault
// PORTS
//  clk            in   1        clock, rising edge
//  rst            in   1        asynchronous reset, active-low (asserted when 0)
//  i_signals      in   Signals  MEM-stage input; address = wdata[31:0], store data = reg2
//  o_signals      out  Signals  registered result toward writeback
//  o_stall        out  1        hold upstream pipeline; i_signals must stay stable while high
//  o_fault        out  1        1-cycle pulse on bus error or timeout
//  m_req_valid    out  1        request valid
//  m_req_ready    in   1        responder accepts request
//  m_req_addr     out  32       word-aligned address {addr[31:2],2'b00}
//  m_req_we       out  1        1 = store, 0 = load
//  m_req_wstrb    out  4        byte-lane enables
//  m_req_wdata    out  32       lane-shifted store data
//  m_rsp_valid    in   1        response valid; sampled only in state RSP
//  m_rsp_rdata    in   32       raw 32-bit read word
//  m_rsp_err      in   1        error qualifier, valid with m_rsp_valid
// BEHAVIOUR
//  Reset (rst=0, async):
//   - state=IDLE, timeout counter=0.
//   - o_signals='0, all m_req_* = 0, o_fault=0.
//   - o_stall is forced to 0.
//   - Reset mid-transaction drops the request at once. The responder must discard it.
//  claim = state==IDLE && (memr|memw) && wdata[MMIO_BIT]. o_stall = claim | state∈{REQ,RSP}. o_stall is combinational.
//  IDLE:
//   - Not claimed: o_signals <= i_signals each cycle. This is the same 1-cycle pass-through as RAM.
//   - Claimed: latch addr, we, wstrb, wdata, memt; go to REQ. o_signals is held.
//  REQ: m_req_valid=1, request fields held stable.
//   - m_req_ready=1 -> RSP at that edge.
//   - Counter increments every cycle from REQ entry.
//  RSP: wait for m_rsp_valid.
//   - On m_rsp_valid: o_signals <= i_signals with wdata replaced by the result; go to DONE.
//   - A response in the same cycle as the request handshake is not legal.
//  Timeout: counter == TIMEOUT_CYCLES-1 in REQ or RSP -> DONE as a fault.
//  Fault (timeout or m_rsp_err): o_signals.wdata=0, o_signals.wback=0, o_fault=1 for the DONE cycle.
//  DONE: o_stall=0, o_signals held, counter cleared.
//   - Next edge -> IDLE. DONE never claims, so the same instruction is not reissued.
//  Lane rules (k = addr[1:0]):
//   - Byte: wstrb = 1<<k; wdata = reg2<<8k.
//   - Half: addr[1]=0 -> strb 0011, shift 0; addr[1]=1 -> strb 1100, shift 16. addr[0] is ignored.
//   - Word: strb 1111, shift 0.
//   - Loads: m_req_wstrb = the same mask, m_req_wdata = 0.
//  Results:
//   - Load: LoadByte/LoadHalf sign-extend rdata[shift+:8/16]; ULoad* zero-extend; LoadWord passes rdata. wdata[32]=0.
//   - Store: wdata=0.
//  Best-case latency, claim at cycle N: req_valid N+1 with ready; rsp N+2; o_signals updated and DONE at N+3 edge; stall low in N+3.
// STRUCTURE
//  Mem package gets:
//   - MmioState enum {IDLE,REQ,RSP,DONE}
//   - MMIO_BIT default constant
//   - function lane_mask(memt, addr[1:0]) returning {strb, shift}, shared with RAM
//  Sub-module mmio_lane_align: combinational strobe/shift for stores, and extract plus sign/zero-extend for loads.
// TESTING
//  1. SW reg2=0xDEADBEEF @0x01000004, ready immediately, rsp next cycle:
//     -> addr 0x01000004, we=1, strb 1111, wdata 0xDEADBEEF; o_stall 3 cycles; o_signals.wdata=0.
//  2. LB @0x01000003, rdata=0x80xxxxxx -> wdata 0xFFFFFF80. LBU same -> 0x00000080. strb 1000 in both.
//  3. SH reg2=0x1234 @0x01000002 -> strb 1100, wdata 0x12340000. LH rdata 0x8001xxxx -> 0xFFFF8001.
//  4. ready held low 5 cycles: req fields stable throughout, o_stall high throughout; completes normally.
//     Responder silent with TIMEOUT_CYCLES=8: fault pulse, wback=0, wdata=0.
//  5. m_rsp_err=1 on LW -> o_fault 1 cycle, wback=0. LW @0x00000010 (bit24=0) -> no request, no stall, pass-through.
//  6. rst low during RSP: m_req_valid=0 and o_signals=0 immediately.
//     After release, a fresh SB @0x01000001 -> strb 0010, wdata = reg2[7:0]<<8.

Source files
------------

// File: rtl/mmio_master_pkg.sv
// Shared memory-stage types for the MMIO initiator and the block RAM.
// Contents:
//   MemType   - access width / signedness carried in the Signals bundle
//   Signals   - pipeline bundle consumed and produced by the MEM stage
//   MmioState - bus initiator FSM states
//   LaneMask  - byte strobes plus bit shift for one access
//   lane_mask - maps (memt, addr[1:0]) to a LaneMask
package mmio_master_pkg;

    localparam int MMIO_BIT_DEFAULT = 24;
    localparam int TIMEOUT_DEFAULT  = 255;

    typedef enum logic [2:0] {
        MT_B  = 3'd0,   // signed byte
        MT_H  = 3'd1,   // signed half
        MT_W  = 3'd2,   // word
        MT_BU = 3'd4,   // unsigned byte
        MT_HU = 3'd5    // unsigned half
    } MemType;

    // wdata carries the address into MEM and the result out of it.
    typedef struct packed {
        logic        memr;
        logic        memw;
        MemType      memt;
        logic        wback;
        logic [4:0]  rd;
        logic [31:0] reg2;
        logic [32:0] wdata;
    } Signals;

    typedef enum logic [1:0] {IDLE, REQ, RSP, DONE} MmioState;

    typedef struct packed {
        logic [3:0] strb;
        logic [4:0] shift;
    } LaneMask;

    function automatic LaneMask lane_mask(input MemType memt, input logic [1:0] addr_lo);
        LaneMask m;
        case (memt)
            MT_B, MT_BU: begin
                m.strb  = 4'b0001 << addr_lo;
                m.shift = {addr_lo, 3'b000};
            end
            // Halfwords ignore addr[0]: the lane is chosen by addr[1] alone.
            MT_H, MT_HU: begin
                m.strb  = addr_lo[1] ? 4'b1100 : 4'b0011;
                m.shift = addr_lo[1] ? 5'd16 : 5'd0;
            end
            default: begin
                m.strb  = 4'b1111;
                m.shift = 5'd0;
            end
        endcase
        return m;
    endfunction

endpackage

// File: rtl/mmio_lane_align.sv
// Byte-lane alignment for MMIO accesses.
// Store side: strobe, shift and lane-shifted data from the live instruction.
// Load side : extracts the addressed byte/half from the raw read word and
//             sign- or zero-extends it according to the latched access type.
// Ports:
//   st_memt, st_addr_lo, st_reg2 -> st_strb, st_shift, st_wdata
//   ld_memt, ld_shift, ld_rdata  -> ld_result
module mmio_lane_align
    import mmio_master_pkg::*;
(
    input  MemType      st_memt,
    input  logic [1:0]  st_addr_lo,
    input  logic [31:0] st_reg2,
    output logic [3:0]  st_strb,
    output logic [4:0]  st_shift,
    output logic [31:0] st_wdata,
    input  MemType      ld_memt,
    input  logic [4:0]  ld_shift,
    input  logic [31:0] ld_rdata,
    output logic [31:0] ld_result
);

    LaneMask            mask;
    logic [31:0]        lane;
    logic signed [7:0]  lane_b;
    logic signed [15:0] lane_h;

    always_comb begin
        mask     = lane_mask(st_memt, st_addr_lo);
        st_strb  = mask.strb;
        st_shift = mask.shift;
        st_wdata = st_reg2 << mask.shift;

        lane   = ld_rdata >> ld_shift;
        lane_b = $signed(lane[7:0]);
        lane_h = $signed(lane[15:0]);
        case (ld_memt)
            MT_B:    ld_result = 32'(lane_b);
            MT_H:    ld_result = 32'(lane_h);
            MT_BU:   ld_result = {24'd0, lane[7:0]};
            MT_HU:   ld_result = {16'd0, lane[15:0]};
            default: ld_result = lane;
        endcase
    end

endmodule

// File: rtl/mmio_master.sv
// MEM-stage bus initiator for the MMIO region (address bit MMIO_BIT set).
// Turns loads/stores into a valid/ready request, stalls the pipeline until
// the peripheral responds (or the timeout expires), then presents the
// aligned and extended result on o_signals.
// Ports:
//   clk, rst (async, active-low)
//   i_signals / o_signals  - MEM-stage bundle in, registered bundle out
//   o_stall                - hold upstream (combinational)
//   o_fault                - one-cycle pulse on bus error or timeout
//   m_req_*                - request channel (valid/ready)
//   m_rsp_*                - response channel (valid only)
module mmio_master
    import mmio_master_pkg::*;
#(
    parameter int MMIO_BIT       = MMIO_BIT_DEFAULT,
    parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  Signals      i_signals,
    output Signals      o_signals,
    output logic        o_stall,
    output logic        o_fault,
    output logic        m_req_valid,
    input  logic        m_req_ready,
    output logic [31:0] m_req_addr,
    output logic        m_req_we,
    output logic [3:0]  m_req_wstrb,
    output logic [31:0] m_req_wdata,
    input  logic        m_rsp_valid,
    input  logic [31:0] m_rsp_rdata,
    input  logic        m_rsp_err
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    MmioState           state_q, state_d;
    logic [CNT_W-1:0]   cnt_q;
    MemType             memt_q;
    logic [4:0]         shift_q;
    logic               fault_q;
    logic               claim, timeout;
    logic [3:0]         st_strb;
    logic [4:0]         st_shift;
    logic [31:0]        st_wdata, ld_result;
    Signals             rsp_sig, flt_sig;

    mmio_lane_align u_align (
        .st_memt    (i_signals.memt),
        .st_addr_lo (i_signals.wdata[1:0]),
        .st_reg2    (i_signals.reg2),
        .st_strb    (st_strb),
        .st_shift   (st_shift),
        .st_wdata   (st_wdata),
        .ld_memt    (memt_q),
        .ld_shift   (shift_q),
        .ld_rdata   (m_rsp_rdata),
        .ld_result  (ld_result)
    );

    always_comb begin
        claim   = (state_q == IDLE) && (i_signals.memr || i_signals.memw)
                  && i_signals.wdata[MMIO_BIT];
        timeout = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

        state_d = state_q;
        case (state_q)
            IDLE: if (claim) state_d = REQ;
            REQ:  if (timeout) state_d = DONE;
                  else if (m_req_ready) state_d = RSP;
            // A response arriving on the timeout cycle still completes normally.
            RSP:  if (m_rsp_valid || timeout) state_d = DONE;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // The instruction is still on i_signals (held by the stall), so the
        // result bundle is rebuilt from it with wdata replaced.
        rsp_sig       = i_signals;
        rsp_sig.wdata = m_req_we ? 33'd0 : {1'b0, ld_result};
        if (m_rsp_err) begin
            rsp_sig.wdata = 33'd0;
            rsp_sig.wback = 1'b0;
        end
        flt_sig       = i_signals;
        flt_sig.wdata = 33'd0;
        flt_sig.wback = 1'b0;

        // Reset must release the pipeline even while an MMIO op is presented.
        o_stall     = rst && (claim || state_q == REQ || state_q == RSP);
        m_req_valid = (state_q == REQ);
        o_fault     = (state_q == DONE) && fault_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            memt_q      <= MT_B;
            shift_q     <= '0;
            fault_q     <= 1'b0;
            o_signals   <= '0;
            m_req_addr  <= '0;
            m_req_we    <= 1'b0;
            m_req_wstrb <= '0;
            m_req_wdata <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    cnt_q   <= '0;
                    fault_q <= 1'b0;
                    if (claim) begin
                        m_req_addr  <= {i_signals.wdata[31:2], 2'b00};
                        m_req_we    <= i_signals.memw;
                        m_req_wstrb <= st_strb;
                        m_req_wdata <= i_signals.memw ? st_wdata : 32'd0;
                        memt_q      <= i_signals.memt;
                        shift_q     <= st_shift;
                    end else begin
                        o_signals <= i_signals;
                    end
                end
                REQ, RSP: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (state_q == RSP && m_rsp_valid) begin
                        o_signals <= rsp_sig;
                        fault_q   <= m_rsp_err;
                    end else if (timeout) begin
                        o_signals <= flt_sig;
                        fault_q   <= 1'b1;
                    end
                end
                default: begin
                    cnt_q   <= '0;
                    fault_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mmio_master.sv
// Scoreboard bench for mmio_master: stimulus pushes expected requests and
// completions; a monitor pops and compares them as the DUT presents them.
module tb_mmio_master;
    import mmio_master_pkg::*;

    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  strb;
        logic [31:0] wdata;
    } req_t;

    typedef struct packed {
        logic [32:0] wdata;
        logic        wback;
        logic        fault;
    } done_t;

    logic        clk = 1'b0;
    logic        rst;
    Signals      i_signals, o_signals;
    logic        o_stall, o_fault;
    logic        m_req_valid, m_req_ready, m_req_we;
    logic [31:0] m_req_addr, m_req_wdata;
    logic [3:0]  m_req_wstrb;
    logic        m_rsp_valid, m_rsp_err;
    logic [31:0] m_rsp_rdata;

    int errors = 0;
    int checks = 0;

    req_t  req_q[$];
    done_t done_q[$];

    // Responder configuration, written by stimulus between transactions.
    int          ready_delay = 0;
    bit          no_rsp      = 1'b0;
    bit          rsp_err     = 1'b0;
    logic [31:0] rsp_rdata   = 32'd0;

    always #5 clk = ~clk;

    mmio_master #(.MMIO_BIT(24), .TIMEOUT_CYCLES(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .i_signals   (i_signals),
        .o_signals   (o_signals),
        .o_stall     (o_stall),
        .o_fault     (o_fault),
        .m_req_valid (m_req_valid),
        .m_req_ready (m_req_ready),
        .m_req_addr  (m_req_addr),
        .m_req_we    (m_req_we),
        .m_req_wstrb (m_req_wstrb),
        .m_req_wdata (m_req_wdata),
        .m_rsp_valid (m_rsp_valid),
        .m_rsp_rdata (m_rsp_rdata),
        .m_rsp_err   (m_rsp_err)
    );

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic Signals mk(input logic r, input logic w, input MemType t,
                                  input logic [31:0] addr, input logic [31:0] r2,
                                  input logic wb);
        Signals s;
        s       = '0;
        s.memr  = r;
        s.memw  = w;
        s.memt  = t;
        s.wdata = {1'b0, addr};
        s.reg2  = r2;
        s.wback = wb;
        s.rd    = 5'd7;
        return s;
    endfunction

    task automatic push_req(input logic [31:0] a, input logic we, input logic [3:0] s,
                            input logic [31:0] d);
        req_t r;
        r.addr = a; r.we = we; r.strb = s; r.wdata = d;
        req_q.push_back(r);
    endtask

    task automatic push_done(input logic [32:0] d, input logic wb, input logic f);
        done_t e;
        e.wdata = d; e.wback = wb; e.fault = f;
        done_q.push_back(e);
    endtask

    // Responder: raises ready after ready_delay valid cycles, answers one
    // cycle after the handshake unless no_rsp is set.
    initial begin
        bit rsp_due;
        int wait_cnt;
        rsp_due = 1'b0; wait_cnt = 0;
        m_req_ready = 1'b0; m_rsp_valid = 1'b0; m_rsp_err = 1'b0; m_rsp_rdata = 32'd0;
        forever begin
            @(negedge clk);
            m_rsp_valid = 1'b0;
            m_rsp_err   = 1'b0;
            if (!rst) begin
                m_req_ready = 1'b0; rsp_due = 1'b0; wait_cnt = 0;
            end else if (rsp_due) begin
                m_req_ready = 1'b0; rsp_due = 1'b0; wait_cnt = 0;
                if (!no_rsp) begin
                    m_rsp_valid = 1'b1;
                    m_rsp_err   = rsp_err;
                    m_rsp_rdata = rsp_rdata;
                end
            end else if (m_req_valid && !m_req_ready) begin
                if (wait_cnt >= ready_delay) begin
                    m_req_ready = 1'b1;
                    rsp_due     = 1'b1;
                end else begin
                    wait_cnt++;
                end
            end
        end
    end

    // Monitor: request fields on every valid cycle, completion when stall falls.
    initial begin
        req_t  cur;
        done_t exp_d;
        logic  prev_valid, prev_stall, prev_rst;
        cur = '0; prev_valid = 1'b0; prev_stall = 1'b0; prev_rst = 1'b0;
        forever begin
            @(negedge clk);
            if (rst && prev_rst) begin
                if (m_req_valid) begin
                    if (!prev_valid) begin
                        if (req_q.size() == 0) chk("req_unexpected", 128'(1), 128'(0));
                        else cur = req_q.pop_front();
                    end
                    chk("req_addr",  128'(m_req_addr),  128'(cur.addr));
                    chk("req_we",    128'(m_req_we),    128'(cur.we));
                    chk("req_wstrb", 128'(m_req_wstrb), 128'(cur.strb));
                    chk("req_wdata", 128'(m_req_wdata), 128'(cur.wdata));
                end
                if (prev_stall && !o_stall) begin
                    if (done_q.size() == 0) begin
                        chk("done_unexpected", 128'(1), 128'(0));
                    end else begin
                        exp_d = done_q.pop_front();
                        chk("done_wdata", 128'(o_signals.wdata), 128'(exp_d.wdata));
                        chk("done_wback", 128'(o_signals.wback), 128'(exp_d.wback));
                        chk("done_fault", 128'(o_fault),         128'(exp_d.fault));
                    end
                end else begin
                    chk("fault_idle", 128'(o_fault), 128'(0));
                end
            end
            prev_valid = m_req_valid;
            prev_stall = o_stall;
            prev_rst   = rst;
        end
    end

    Signals idle_sig;

    task automatic run_op(input string name, input Signals s, input int exp_stall);
        int  n;
        bit  fin;
        n = 0; fin = 1'b0;
        @(posedge clk); #1;
        i_signals = s;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (o_stall) n++;
            else begin
                fin = 1'b1;
                break;
            end
        end
        if (!fin) chk({name, "_stall_bound"}, 128'(0), 128'(1));
        chk({name, "_stall_cycles"}, 128'(n), 128'(exp_stall));
        @(posedge clk); #1;
        i_signals = idle_sig;
    endtask

    initial begin
        Signals pt, rs;
        idle_sig  = mk(1'b0, 1'b0, MT_W, 32'h0000_0100, 32'h0000_0001, 1'b0);
        rst       = 1'b0;
        i_signals = mk(1'b1, 1'b0, MT_W, 32'h0100_0000, 32'd0, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_o_signals", 128'(o_signals),   128'(0));
        chk("rst_stall",     128'(o_stall),     128'(0));
        chk("rst_req_valid", 128'(m_req_valid), 128'(0));
        chk("rst_req_addr",  128'(m_req_addr),  128'(0));
        chk("rst_req_we",    128'(m_req_we),    128'(0));
        chk("rst_req_wstrb", 128'(m_req_wstrb), 128'(0));
        chk("rst_req_wdata", 128'(m_req_wdata), 128'(0));
        chk("rst_fault",     128'(o_fault),     128'(0));
        i_signals = idle_sig;
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);

        // SW word
        push_req(32'h0100_0004, 1'b1, 4'b1111, 32'hDEAD_BEEF);
        push_done(33'd0, 1'b0, 1'b0);
        run_op("sw", mk(1'b0, 1'b1, MT_W, 32'h0100_0004, 32'hDEAD_BEEF, 1'b0), 3);

        // LB / LBU on lane 3
        rsp_rdata = 32'h8012_3456;
        push_req(32'h0100_0000, 1'b0, 4'b1000, 32'd0);
        push_done(33'h0_FFFF_FF80, 1'b1, 1'b0);
        run_op("lb", mk(1'b1, 1'b0, MT_B, 32'h0100_0003, 32'd0, 1'b1), 3);
        push_req(32'h0100_0000, 1'b0, 4'b1000, 32'd0);
        push_done(33'h0_0000_0080, 1'b1, 1'b0);
        run_op("lbu", mk(1'b1, 1'b0, MT_BU, 32'h0100_0003, 32'd0, 1'b1), 3);

        // SH / LH on upper half
        push_req(32'h0100_0000, 1'b1, 4'b1100, 32'h1234_0000);
        push_done(33'd0, 1'b0, 1'b0);
        run_op("sh", mk(1'b0, 1'b1, MT_H, 32'h0100_0002, 32'h0000_1234, 1'b0), 3);
        rsp_rdata = 32'h8001_ABCD;
        push_req(32'h0100_0000, 1'b0, 4'b1100, 32'd0);
        push_done(33'h0_FFFF_8001, 1'b1, 1'b0);
        run_op("lh", mk(1'b1, 1'b0, MT_H, 32'h0100_0002, 32'd0, 1'b1), 3);

        // Ready held low for 5 cycles
        ready_delay = 5;
        rsp_rdata   = 32'h1234_5678;
        push_req(32'h0100_0008, 1'b0, 4'b1111, 32'd0);
        push_done(33'h0_1234_5678, 1'b1, 1'b0);
        run_op("lw_slow", mk(1'b1, 1'b0, MT_W, 32'h0100_0008, 32'd0, 1'b1), 8);
        ready_delay = 0;

        // Silent responder -> timeout fault after 8 cycles in REQ/RSP
        no_rsp = 1'b1;
        push_req(32'h0100_000C, 1'b0, 4'b1111, 32'd0);
        push_done(33'd0, 1'b0, 1'b1);
        run_op("lw_tmo", mk(1'b1, 1'b0, MT_W, 32'h0100_000C, 32'd0, 1'b1), 9);
        no_rsp = 1'b0;

        // Bus error
        rsp_err = 1'b1;
        push_req(32'h0100_0010, 1'b0, 4'b1111, 32'd0);
        push_done(33'd0, 1'b0, 1'b1);
        run_op("lw_err", mk(1'b1, 1'b0, MT_W, 32'h0100_0010, 32'd0, 1'b1), 3);
        rsp_err = 1'b0;

        // Non-MMIO load: plain pass-through
        pt = mk(1'b1, 1'b0, MT_W, 32'h0000_0010, 32'h0000_0055, 1'b1);
        @(posedge clk); #1;
        i_signals = pt;
        @(negedge clk);
        chk("pt_stall", 128'(o_stall), 128'(0));
        @(posedge clk); #1;
        chk("pt_o_signals", 128'(o_signals), 128'(pt));
        chk("pt_req_valid", 128'(m_req_valid), 128'(0));
        i_signals = idle_sig;

        // Reset while waiting in RSP
        no_rsp = 1'b1;
        push_req(32'h0100_0014, 1'b0, 4'b1111, 32'd0);
        rs = mk(1'b1, 1'b0, MT_W, 32'h0100_0014, 32'd0, 1'b1);
        @(posedge clk); #1;
        i_signals = rs;
        @(posedge clk);
        @(posedge clk); #1;
        chk("rsp_hold_o_signals", 128'(o_signals), 128'(idle_sig));
        chk("rsp_stall",          128'(o_stall),   128'(1));
        #2 rst = 1'b0;
        #1;
        chk("midrst_req_valid", 128'(m_req_valid), 128'(0));
        chk("midrst_o_signals", 128'(o_signals),   128'(0));
        chk("midrst_stall",     128'(o_stall),     128'(0));
        chk("midrst_req_addr",  128'(m_req_addr),  128'(0));
        @(posedge clk); #1;
        i_signals = idle_sig;
        @(posedge clk); #1;
        rst    = 1'b1;
        no_rsp = 1'b0;
        repeat (2) @(posedge clk);

        // Fresh SB on lane 1 after reset
        push_req(32'h0100_0000, 1'b1, 4'b0010, 32'h0000_A500);
        push_done(33'd0, 1'b0, 1'b0);
        run_op("sb", mk(1'b0, 1'b1, MT_B, 32'h0100_0001, 32'h0000_00A5, 1'b0), 3);

        repeat (3) @(posedge clk);
        chk("req_q_drained",  128'(req_q.size()),  128'(0));
        chk("done_q_drained", 128'(done_q.size()), 128'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

endmodule
